// File: rtl/bsmul_pkg.sv
// Shared types and the bit-sliced ripple adder used by the sequential multiplier.
package bsmul_pkg;

    // Plane arrays are sized for the widest supported build; users zero-pad.
    localparam int LANES_MAX  = 256;
    localparam int PLANES_MAX = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef logic [PLANES_MAX-1:0][LANES_MAX-1:0] plane_arr_t;

    // Each plane word carries one bit position of every lane, so a ripple over
    // planes adds all lanes at once; the final carry is dropped.
    function automatic plane_arr_t bs_add(input plane_arr_t x, input plane_arr_t y,
                                          input int planes);
        plane_arr_t           s;
        logic [LANES_MAX-1:0] c;
        s = '0;
        c = '0;
        for (int k = 0; k < PLANES_MAX; k++) begin
            if (k < planes) begin
                s[k] = x[k] ^ y[k] ^ c;
                c    = (x[k] & y[k]) | (x[k] & c) | (y[k] & c);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/bitsliced_adder.sv
// Combinational modulo-2^PLANES add of two bit-sliced plane arrays.
module bitsliced_adder
    import bsmul_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int PLANES = 4
) (
    input  logic [PLANES-1:0][LANES-1:0] x_i,
    input  logic [PLANES-1:0][LANES-1:0] y_i,
    output logic [PLANES-1:0][LANES-1:0] s_o
);
    plane_arr_t xw, yw, sw;

    always_comb begin
        xw = '0;
        yw = '0;
        for (int k = 0; k < PLANES; k++) begin
            xw[k][LANES-1:0] = x_i[k];
            yw[k][LANES-1:0] = y_i[k];
        end
        sw  = bs_add(xw, yw, PLANES);
        s_o = '0;
        for (int k = 0; k < PLANES; k++) begin
            s_o[k] = sw[k][LANES-1:0];
        end
    end

endmodule

// File: rtl/bitsliced_mul_seq.sv
// Sequential shift-and-add multiplier over LANES bit-sliced unsigned operand pairs.
// Define BSMUL_ACC_EN to add acc_i, which adds the new product onto the previous result.
module bitsliced_mul_seq
    import bsmul_pkg::*;
#(
    parameter int LANES = 16,
    parameter int NBITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NBITS-1:0][LANES-1:0]   a_i,
    input  logic [NBITS-1:0][LANES-1:0]   b_i,
`ifdef BSMUL_ACC_EN
    input  logic                          acc_i,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*NBITS-1:0][LANES-1:0] y_o
);
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_e                         state_q;
    logic [CW-1:0]                  cnt_q;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic [NBITS-1:0][LANES-1:0]    a_q, b_q;
    logic [2*NBITS-1:0][LANES-1:0]  acc_q, acc_d;

    logic [LANES-1:0]               b_sel;
    logic [NBITS-1:0][LANES-1:0]    am;
    logic [2*NBITS-1:0][LANES-1:0]  ext, pp;

    // Partial product for this cycle: A gated by B plane cnt, shifted up cnt planes.
    always_comb begin
        b_sel = '0;
        for (int k = 0; k < NBITS; k++) begin
            if (cnt_q == CW'(k)) b_sel = b_q[k];
        end
        for (int k = 0; k < NBITS; k++) begin
            am[k] = a_q[k] & b_sel;
        end
        ext              = '0;
        ext[NBITS-1:0]   = am;
        pp               = ext << (LANES * int'(cnt_q));
    end

    bitsliced_adder #(
        .LANES  (LANES),
        .PLANES (2*NBITS)
    ) u_add (
        .x_i (acc_q),
        .y_i (pp),
        .s_o (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
`ifdef BSMUL_ACC_EN
                        if (!acc_i) acc_q <= '0;
`else
                        acc_q      <= '0;
`endif
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NBITS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_o       = acc_q;

endmodule

// File: tb/tb_bitsliced_mul_seq.sv
// Directed table-driven bench for bitsliced_mul_seq at (16,2), (8,4) and (8,1).
module tb_bitsliced_mul_seq;

    logic clk, rst;

    logic [1:0][15:0] a0, b0;
    logic [3:0][15:0] y0;
    logic             iv0, ir0, ov0, or0;
    logic [3:0][7:0]  a1, b1;
    logic [7:0][7:0]  y1;
    logic             iv1, ir1, ov1, or1;
    logic [0:0][7:0]  a2, b2;
    logic [1:0][7:0]  y2;
    logic             iv2, ir2, ov2, or2;
`ifdef BSMUL_ACC_EN
    logic             acc0;
`endif

    int n_chk = 0;
    int n_err = 0;

    bitsliced_mul_seq #(.LANES(16), .NBITS(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a_i(a0), .b_i(b0),
`ifdef BSMUL_ACC_EN
        .acc_i(acc0),
`endif
        .out_valid(ov0), .out_ready(or0), .y_o(y0));

    bitsliced_mul_seq #(.LANES(8), .NBITS(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a_i(a1), .b_i(b1),
`ifdef BSMUL_ACC_EN
        .acc_i(1'b0),
`endif
        .out_valid(ov1), .out_ready(or1), .y_o(y1));

    bitsliced_mul_seq #(.LANES(8), .NBITS(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_i(a2), .b_i(b2),
`ifdef BSMUL_ACC_EN
        .acc_i(1'b0),
`endif
        .out_valid(ov2), .out_ready(or2), .y_o(y2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] y;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic [31:0] a, input logic [31:0] b, input logic v);
        case (d)
            0:       begin a0 = a;      b0 = b;      iv0 = v; end
            1:       begin a1 = a;      b1 = b;      iv1 = v; end
            default: begin a2 = a[7:0]; b2 = b[7:0]; iv2 = v; end
        endcase
    endtask

    task automatic set_or(input int d, input logic v);
        case (d)
            0:       or0 = v;
            1:       or1 = v;
            default: or2 = v;
        endcase
    endtask

    function automatic logic [63:0] get_y(input int d);
        case (d)
            0:       return y0;
            1:       return y1;
            default: return {48'h0, y2};
        endcase
    endfunction

    function automatic logic get_ov(input int d);
        case (d)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // Accept one op, scramble the inputs, time out_valid, check result, then drain.
    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] ey, input string nm);
        int lat;
        @(negedge clk);
        check({nm, "_in_ready"}, {63'h0, get_ir(d)}, 64'h1);
        set_in(d, a, b, 1'b1);
        @(posedge clk); #1;
        set_in(d, ~a, ~b, 1'b0);
        lat = 0;
        while (!get_ov(d) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_lat"}, 64'(lat), 64'(lat_of(d)));
        check({nm, "_y"}, get_y(d), ey);
        @(negedge clk);
        set_or(d, 1'b1);
        @(posedge clk); #1;
        set_or(d, 1'b0);
        check({nm, "_drain"}, {62'h0, get_ov(d), get_ir(d)}, 64'h1);
    endtask

    initial begin
        logic [63:0] hold_y;
        int          lat;

        tbl[0]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_0000_0000_FFFF};
        tbl[1]  = '{0, 32'h0001_0000, 32'h0001_0001, 64'h0000_0001_0001_0000};
        tbl[2]  = '{0, 32'h0021_0020, 32'h0001_0021, 64'h0000_0001_0021_0020};
        tbl[3]  = '{0, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0};
        tbl[4]  = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0};
        tbl[5]  = '{0, 32'hFF00_F0F0, 32'hCCCC_AAAA, 64'h8000_4C00_6AC0_A0A0};
        tbl[6]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_0000, 64'h0000_FFFF_FFFF_0000};
        tbl[7]  = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FF00_0000_00FF};
        tbl[8]  = '{1, 32'h00F0_CCAA, 32'h00FF_FFFF, 64'h0000_E098_541E_66AA};
        tbl[9]  = '{2, 32'h0000_00A5, 32'h0000_000F, 64'h0000_0000_0000_0005};
        tbl[10] = '{2, 32'h0000_00FF, 32'h0000_00FF, 64'h0000_0000_0000_00FF};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            set_in(d, 32'h0, 32'h0, 1'b0);
            set_or(d, 1'b0);
        end
`ifdef BSMUL_ACC_EN
        acc0 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset%0d_ir", d), {63'h0, get_ir(d)}, 64'h1);
            check($sformatf("reset%0d_ov", d), {63'h0, get_ov(d)}, 64'h0);
            check($sformatf("reset%0d_y", d), get_y(d), 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].y, $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and in_valid must be ignored in DONE.
        @(negedge clk);
        set_in(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        set_in(0, 32'h0, 32'h0, 1'b0);
        lat = 0;
        while (!ov0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 64'(lat), 64'd2);
        hold_y = 64'hFFFF_0000_0000_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_in(0, $urandom, $urandom, 1'b1);
            @(posedge clk); #1;
            check($sformatf("bp%0d_ov", c), {63'h0, ov0}, 64'h1);
            check($sformatf("bp%0d_ir", c), {63'h0, ir0}, 64'h0);
            check($sformatf("bp%0d_y", c), y0, hold_y);
        end
        @(negedge clk);
        set_or(0, 1'b1);
        @(posedge clk); #1;
        set_or(0, 1'b0);
        check("bp_release", {62'h0, ov0, ir0}, 64'h1);
        @(negedge clk);
        set_in(0, 32'h0, 32'h0, 1'b0);

        // Reset while BUSY with cnt=0 discards the partial product.
        @(negedge clk);
        set_in(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        set_in(0, 32'h0, 32'h0, 1'b0);
        check("rst_busy_ir", {63'h0, ir0}, 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ov", {63'h0, ov0}, 64'h0);
        check("rst_ir", {63'h0, ir0}, 64'h1);
        check("rst_y", y0, 64'h0);
        repeat (4) @(posedge clk);
        #1;
        check("rst_quiet", {62'h0, ov0, ir0}, 64'h1);
        run_op(0, tbl[5].a, tbl[5].b, tbl[5].y, "post_rst");

`ifdef BSMUL_ACC_EN
        acc0 = 1'b0;
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_0000_0000_FFFF, "acc_first");
        acc0 = 1'b1;
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_0000, "acc_second");
        acc0 = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
